serial_frame_ctrl: RTL

Sequencing controller for the team's right-shift serial-to-parallel register. It gates shifting on a start command and counts exactly WIDTH bits per frame. On completion it transfers the word into an output holding register and presents it downstream with a valid/ready handshake, flagging overruns. It sits between a serial line and any parallel consumer (bus, FIFO, CPU register file).

---
 rtl/serial_frame_if.sv | 51 +++++
 rtl/serial_frame_ctrl.sv | 128 ++++++++++++
 2 files changed

// File: rtl/serial_frame_if.sv
// serial_frame_if
// Groups the serial input, control strobes and parallel output handshake of
// serial_frame_ctrl into a single bundle.
//   start       : frame start command (driven by master)
//   serial_in   : serial data bit (driven by master)
//   data_ready  : consumer accepts data this cycle (driven by master)
//   clear_err   : synchronous clear of the sticky overrun flag (driven by master)
//   shift_en    : high while the controller is shifting (combinational)
//   busy        : registered copy of shift_en
//   data        : holding register with the last completed frame
//   data_valid  : holding register contains an unconsumed frame
//   overrun     : sticky flag, a completed frame was dropped
// Modport "master" is the side driving the serial line and consuming words;
// modport "slave" is the controller itself.
interface serial_frame_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             serial_in;
  logic             data_ready;
  logic             clear_err;
  logic             shift_en;
  logic             busy;
  logic [WIDTH-1:0] data;
  logic             data_valid;
  logic             overrun;

  modport master (
    output start,
    output serial_in,
    output data_ready,
    output clear_err,
    input  shift_en,
    input  busy,
    input  data,
    input  data_valid,
    input  overrun
  );

  modport slave (
    input  start,
    input  serial_in,
    input  data_ready,
    input  clear_err,
    output shift_en,
    output busy,
    output data,
    output data_valid,
    output overrun
  );
endinterface

// File: rtl/serial_frame_ctrl.sv
// serial_frame_ctrl
// Sequencing controller for a right-shift serial-to-parallel register. A start
// command launches a frame of exactly WIDTH bits; the first bit received ends
// up in data[0] and the last in data[WIDTH-1]. The completed word is moved
// into a holding register and offered downstream with a valid/ready
// handshake. A word that completes while the holding register is still full
// and not being accepted is dropped and raises a sticky overrun flag.
// Ports:
//   clk    : system clock, all state updates on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : serial_frame_if slave modport (see interface for signal list)
module serial_frame_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_frame_if.slave      bus
);

  localparam int CntW = $clog2(WIDTH);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             busy_q;

  logic [WIDTH-1:0] word;
  logic             complete;
  logic             drop;

  // Word as it will look after the current edge's shift; on the completing
  // edge this is what gets handed to the holding register.
  assign word = {bus.serial_in, shreg_q[WIDTH-1:1]};

  // Frame sequencing: IDLE waits for start, SHIFT takes one bit per edge and
  // returns to IDLE on the edge that captures the WIDTH-th bit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        shreg_d = word;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d  = IDLE;
          cnt_d    = '0;
          complete = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output holding register and handshake. An acceptance on the completing
  // edge frees the slot, so the new word replaces the consumed one and valid
  // stays high; otherwise a full slot forces the new word to be dropped.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    drop      = 1'b0;
    if (complete) begin
      if (!valid_q || bus.data_ready) begin
        data_d  = word;
        valid_d = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else if (valid_q && bus.data_ready) begin
      valid_d = 1'b0;
    end
  end

  // Sticky overrun: a new drop takes priority over a clear on the same edge.
  always_comb begin
    overrun_d = overrun_q;
    if (drop) begin
      overrun_d = 1'b1;
    end else if (bus.clear_err) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      // Registered from next state so it tracks shift_en cycle for cycle.
      busy_q    <= (state_d == SHIFT);
    end
  end

  assign bus.shift_en   = (state_q == SHIFT);
  assign bus.busy       = busy_q;
  assign bus.data       = data_q;
  assign bus.data_valid = valid_q;
  assign bus.overrun    = overrun_q;

endmodule
